// File: rtl/hqm_aw_fifo_control_mc_wtcfg_pkg.sv
// Shared types and helpers for the multi-channel FIFO controller with per-channel
// parity-protected high-watermark configuration.
package hqm_aw_fifo_control_mc_wtcfg_pkg;

  typedef struct packed {
    logic [31:0] wdata;
  } cfg_req_t;

  typedef struct packed {
    logic [9:0] rsvd;
    logic       par_err_seen;
    logic       sticky_uf;
    logic       sticky_of;
    logic       empty;
    logic       afull;
    logic       full;
    logic [7:0] size;
    logic [7:0] hwm;
  } aw_mcfifo_status_t;

  function automatic int aw_logb2(input int v);
    int r;
    r = 0;
    for (int t = v; t > 1; t = t >> 1) r++;
    return r;
  endfunction

  // Odd parity over the low w bits: data plus parity always holds an odd count of ones.
  function automatic logic odd_par(input logic [7:0] v, input int w);
    logic p;
    p = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < w) p = p ^ v[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/hqm_aw_fifo_control_mc_wtcfg_chan.sv
// Per-channel FIFO bookkeeping: pointers, occupancy, registered flags, sticky errors
// and the parity-protected high-watermark register with self-recovery.
module hqm_aw_fifo_control_mc_wtcfg_chan
  import hqm_aw_fifo_control_mc_wtcfg_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int DEFAULT_HWM = 1,
  parameter int DEPTHB2     = 3,
  parameter int DEPTHWIDTH  = 4,
  parameter int WMWIDTH     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_req,
  input  logic               pop_req,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_hwm,
  output logic               push_ok,
  output logic               pop_ok,
  output logic [DEPTHB2-1:0] wp,
  output logic [DEPTHB2-1:0] rp,
  output logic               full,
  output logic               afull,
  output logic               empty,
  output logic               err_of,
  output logic               err_uf,
  output logic               par_err,
  output aw_mcfifo_status_t  status
);

  localparam logic [7:0] DEF_HWM = 8'(DEFAULT_HWM);
  localparam logic       DEF_PAR = odd_par(DEF_HWM, WMWIDTH);

  logic [DEPTHB2-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [DEPTHWIDTH-1:0] size_q, size_d;
  logic                  full_q, full_d, afull_q, afull_d, empty_q, empty_d;
  logic                  sticky_of_q, sticky_of_d, sticky_uf_q, sticky_uf_d;
  logic                  par_seen_q, par_seen_d;
  logic [7:0]            hwm_q, hwm_d;
  logic                  par_q, par_d;
  logic                  par_rd;

  assign par_rd = par_q;

  always_comb begin
    push_ok     = push_req & ~full_q;
    pop_ok      = pop_req & ~empty_q;
    err_of      = push_req & full_q;
    err_uf      = pop_req & empty_q;
    par_err     = (odd_par(hwm_q, WMWIDTH) != par_rd);
    wp_d        = wp_q + DEPTHB2'(push_ok);
    rp_d        = rp_q + DEPTHB2'(pop_ok);
    size_d      = size_q + DEPTHWIDTH'(push_ok) - DEPTHWIDTH'(pop_ok);
    hwm_d       = hwm_q;
    par_d       = par_q;
    sticky_of_d = sticky_of_q | err_of;
    sticky_uf_d = sticky_uf_q | err_uf;
    par_seen_d  = par_seen_q;
    // A CFG write replaces the watermark outright, so it also overrides parity recovery.
    if (cfg_we) begin
      hwm_d       = cfg_hwm;
      par_d       = odd_par(cfg_hwm, WMWIDTH);
      sticky_of_d = err_of;
      sticky_uf_d = err_uf;
      par_seen_d  = 1'b0;
    end else if (par_err) begin
      hwm_d      = DEF_HWM;
      par_d      = DEF_PAR;
      par_seen_d = 1'b1;
    end
    full_d  = (size_d == DEPTHWIDTH'(DEPTH));
    empty_d = (size_d == '0);
    afull_d = (9'(size_d) >= 9'(hwm_d));
  end

  always_comb begin
    status              = '0;
    status.hwm          = hwm_q;
    status.size         = 8'(size_q);
    status.full         = full_q;
    status.afull        = afull_q;
    status.empty        = empty_q;
    status.sticky_of    = sticky_of_q;
    status.sticky_uf    = sticky_uf_q;
    status.par_err_seen = par_seen_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q        <= '0;
      rp_q        <= '0;
      size_q      <= '0;
      full_q      <= 1'b0;
      afull_q     <= (DEFAULT_HWM == 0);
      empty_q     <= 1'b1;
      sticky_of_q <= 1'b0;
      sticky_uf_q <= 1'b0;
      par_seen_q  <= 1'b0;
      hwm_q       <= DEF_HWM;
      par_q       <= DEF_PAR;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      size_q      <= size_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      empty_q     <= empty_d;
      sticky_of_q <= sticky_of_d;
      sticky_uf_q <= sticky_uf_d;
      par_seen_q  <= par_seen_d;
      hwm_q       <= hwm_d;
      par_q       <= par_d;
    end
  end

  assign wp    = wp_q;
  assign rp    = rp_q;
  assign full  = full_q;
  assign afull = afull_q;
  assign empty = empty_q;

endmodule

// File: rtl/hqm_aw_fifo_control_mc_wtcfg.sv
// Multi-channel FIFO controller: NUM_CH logical FIFOs statically partitioned in one
// shared 1R1W memory, with per-channel CFG watermark/status registers.
module hqm_aw_fifo_control_mc_wtcfg
  import hqm_aw_fifo_control_mc_wtcfg_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DEPTH       = 8,
  parameter int DWIDTH      = 16,
  parameter int DEFAULT_HWM = 1,
  parameter int CHB2        = aw_logb2(NUM_CH - 1) + 1,
  parameter int DEPTHB2     = aw_logb2(DEPTH - 1) + 1,
  parameter int DEPTHWIDTH  = aw_logb2(DEPTH) + 1,
  parameter int WMWIDTH     = aw_logb2(DEPTH + 1) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       cfg_write,
  input  logic [NUM_CH-1:0]       cfg_read,
  input  cfg_req_t                cfg_req,
  output logic                    cfg_ack,
  output logic                    cfg_err,
  output logic [31:0]             cfg_rdata,
  input  logic                    push,
  input  logic [CHB2-1:0]         push_ch,
  input  logic [DWIDTH-1:0]       push_data,
  input  logic                    pop,
  input  logic [CHB2-1:0]         pop_ch,
  output logic                    pop_data_v,
  output logic [DWIDTH-1:0]       pop_data,
  output logic                    mem_we,
  output logic                    mem_re,
  output logic [CHB2+DEPTHB2-1:0] mem_waddr,
  output logic [CHB2+DEPTHB2-1:0] mem_raddr,
  output logic [DWIDTH-1:0]       mem_wdata,
  input  logic [DWIDTH-1:0]       mem_rdata,
  output logic [NUM_CH-1:0]       fifo_full,
  output logic [NUM_CH-1:0]       fifo_afull,
  output logic [NUM_CH-1:0]       fifo_empty,
  output logic [NUM_CH-1:0]       error_of,
  output logic [NUM_CH-1:0]       error_uf,
  output logic                    error_par
);

  logic [NUM_CH-1:0]  push_req, pop_req, push_ok, pop_ok;
  logic [NUM_CH-1:0]  err_of, err_uf, par_err, cfg_we, strobes;
  logic [DEPTHB2-1:0] wp [NUM_CH];
  logic [DEPTHB2-1:0] rp [NUM_CH];
  aw_mcfifo_status_t  status [NUM_CH];
  logic               multi;
  logic [31:0]        rdata_sel;
  logic               unused_cfg;

  logic               cfg_ack_q, cfg_ack_d, cfg_err_q, cfg_err_d;
  logic [31:0]        cfg_rdata_q, cfg_rdata_d;
  logic               pop_data_v_q, pop_data_v_d;
  logic [NUM_CH-1:0]  error_of_q, error_of_d, error_uf_q, error_uf_d;
  logic               error_par_q, error_par_d;

  assign unused_cfg = ^cfg_req.wdata[31:8];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      push_req[i] = push && (push_ch == CHB2'(i));
      pop_req[i]  = pop && (pop_ch == CHB2'(i));
    end
    // Two or more strobes in one cycle is an illegal access and must not touch state.
    strobes = cfg_write | cfg_read;
    multi   = |(strobes & (strobes - 1'b1));
    cfg_we  = cfg_write & {NUM_CH{~multi}};
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hqm_aw_fifo_control_mc_wtcfg_chan #(
      .DEPTH       (DEPTH),
      .DEFAULT_HWM (DEFAULT_HWM),
      .DEPTHB2     (DEPTHB2),
      .DEPTHWIDTH  (DEPTHWIDTH),
      .WMWIDTH     (WMWIDTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_req (push_req[i]),
      .pop_req  (pop_req[i]),
      .cfg_we   (cfg_we[i]),
      .cfg_hwm  (cfg_req.wdata[7:0]),
      .push_ok  (push_ok[i]),
      .pop_ok   (pop_ok[i]),
      .wp       (wp[i]),
      .rp       (rp[i]),
      .full     (fifo_full[i]),
      .afull    (fifo_afull[i]),
      .empty    (fifo_empty[i]),
      .err_of   (err_of[i]),
      .err_uf   (err_uf[i]),
      .par_err  (par_err[i]),
      .status   (status[i])
    );
  end

  always_comb begin
    mem_we    = |push_ok;
    mem_waddr = {push_ch, wp[push_ch]};
    mem_wdata = push_data;
    mem_re    = |pop_ok;
    mem_raddr = {pop_ch, rp[pop_ch]};
    rdata_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_read[i]) rdata_sel = rdata_sel | status[i];
    end
    cfg_ack_d    = |strobes;
    cfg_err_d    = multi;
    cfg_rdata_d  = multi ? '0 : rdata_sel;
    pop_data_v_d = mem_re;
    error_of_d   = err_of;
    error_uf_d   = err_uf;
    error_par_d  = |par_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ack_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_rdata_q  <= '0;
      pop_data_v_q <= 1'b0;
      error_of_q   <= '0;
      error_uf_q   <= '0;
      error_par_q  <= 1'b0;
    end else begin
      cfg_ack_q    <= cfg_ack_d;
      cfg_err_q    <= cfg_err_d;
      cfg_rdata_q  <= cfg_rdata_d;
      pop_data_v_q <= pop_data_v_d;
      error_of_q   <= error_of_d;
      error_uf_q   <= error_uf_d;
      error_par_q  <= error_par_d;
    end
  end

  assign cfg_ack    = cfg_ack_q;
  assign cfg_err    = cfg_err_q;
  assign cfg_rdata  = cfg_rdata_q;
  assign pop_data_v = pop_data_v_q;
  assign pop_data   = mem_rdata;
  assign error_of   = error_of_q;
  assign error_uf   = error_uf_q;
  assign error_par  = error_par_q;

endmodule

// File: tb/tb_hqm_aw_fifo_control_mc_wtcfg.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_hqm_aw_fifo_control_mc_wtcfg;
  import hqm_aw_fifo_control_mc_wtcfg_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DEPTH = 8;
  localparam int DWIDTH = 16;
  localparam int DEFAULT_HWM = 1;

  logic clk, rst_n;
  logic [3:0] cfg_write, cfg_read;
  cfg_req_t cfg_req;
  logic cfg_ack, cfg_err;
  logic [31:0] cfg_rdata;
  logic push, pop, pop_data_v;
  logic [1:0] push_ch, pop_ch;
  logic [15:0] push_data, pop_data, mem_wdata, mem_rdata;
  logic mem_we, mem_re;
  logic [4:0] mem_waddr, mem_raddr;
  logic [3:0] fifo_full, fifo_afull, fifo_empty, error_of, error_uf;
  logic error_par;
  logic bad_par;

  hqm_aw_fifo_control_mc_wtcfg #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DWIDTH(DWIDTH), .DEFAULT_HWM(DEFAULT_HWM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_write(cfg_write), .cfg_read(cfg_read), .cfg_req(cfg_req),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .cfg_rdata(cfg_rdata),
    .push(push), .push_ch(push_ch), .push_data(push_data),
    .pop(pop), .pop_ch(pop_ch), .pop_data_v(pop_data_v), .pop_data(pop_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_full(fifo_full), .fifo_afull(fifo_afull), .fifo_empty(fifo_empty),
    .error_of(error_of), .error_uf(error_uf), .error_par(error_par)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared 1R1W memory with one cycle of read latency.
  logic [15:0] mem [32];
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  int q [NUM_CH][$];
  int hwm_m [NUM_CH];
  bit sof [NUM_CH];
  bit suf [NUM_CH];
  bit pse [NUM_CH];
  int wcnt [NUM_CH];
  int rcnt [NUM_CH];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      q[c].delete();
      hwm_m[c] = DEFAULT_HWM;
      sof[c] = 0; suf[c] = 0; pse[c] = 0;
      wcnt[c] = 0; rcnt[c] = 0;
    end
  endtask

  function automatic logic [31:0] model_status(input int c);
    logic [31:0] s;
    s = '0;
    s[7:0]  = 8'(hwm_m[c]);
    s[15:8] = 8'(q[c].size());
    s[16]   = (q[c].size() == DEPTH);
    s[17]   = (q[c].size() >= hwm_m[c]);
    s[18]   = (q[c].size() == 0);
    s[19]   = sof[c];
    s[20]   = suf[c];
    s[21]   = pse[c];
    return s;
  endfunction

  function automatic logic model_par(input int h);
    logic [7:0] hb;
    hb = 8'(h);
    return ~(hb[0] ^ hb[1] ^ hb[2] ^ hb[3]);
  endfunction

  task automatic check_flags(input string tag);
    logic [3:0] ef, ea, ee;
    for (int c = 0; c < NUM_CH; c++) begin
      ef[c] = (q[c].size() == DEPTH);
      ea[c] = (q[c].size() >= hwm_m[c]);
      ee[c] = (q[c].size() == 0);
    end
    chk({tag, ".full"}, 64'(fifo_full), 64'(ef));
    chk({tag, ".afull"}, 64'(fifo_afull), 64'(ea));
    chk({tag, ".empty"}, 64'(fifo_empty), 64'(ee));
  endtask

  // One clock of stimulus: drive, check same-cycle memory strobes, advance, check registered results.
  task automatic step(input bit pe, input int pc, input logic [15:0] pd, input bit oe, input int oc,
                      input logic [3:0] cw, input logic [3:0] cr, input logic [31:0] wd, input bit inj);
    logic [3:0] strobes, exp_of, exp_uf;
    bit multi, push_acc, pop_acc;
    logic [31:0] exp_rd;
    logic [15:0] exp_pd;
    logic [4:0] exp_wa, exp_ra;
    push = pe; push_ch = 2'(pc); push_data = pd;
    pop = oe; pop_ch = 2'(oc);
    cfg_write = cw; cfg_read = cr; cfg_req.wdata = wd;
    strobes = cw | cr;
    multi = ($countones(strobes) > 1);
    exp_rd = '0;
    if (!multi) for (int c = 0; c < NUM_CH; c++) if (cr[c]) exp_rd = model_status(c);
    push_acc = pe && (q[pc].size() < DEPTH);
    pop_acc = oe && (q[oc].size() > 0);
    exp_of = '0; exp_uf = '0; exp_pd = '0;
    if (pe && !push_acc) exp_of[pc] = 1'b1;
    if (oe && !pop_acc) exp_uf[oc] = 1'b1;
    exp_wa = {2'(pc), 3'(wcnt[pc])};
    exp_ra = {2'(oc), 3'(rcnt[oc])};
    if (inj) begin
      bad_par = ~model_par(hwm_m[1]);
      force dut.g_ch[1].u_ch.par_rd = bad_par;
    end
    #1;
    chk("mem_we", 64'(mem_we), 64'(push_acc));
    if (push_acc) begin
      chk("mem_waddr", 64'(mem_waddr), 64'(exp_wa));
      chk("mem_wdata", 64'(mem_wdata), 64'(pd));
    end
    chk("mem_re", 64'(mem_re), 64'(pop_acc));
    if (pop_acc) chk("mem_raddr", 64'(mem_raddr), 64'(exp_ra));
    if (pop_acc) begin exp_pd = 16'(q[oc].pop_front()); rcnt[oc]++; end
    if (push_acc) begin q[pc].push_back(int'(pd)); wcnt[pc]++; end
    if (inj && !(cw[1] && !multi)) begin hwm_m[1] = DEFAULT_HWM; pse[1] = 1; end
    if (!multi) for (int c = 0; c < NUM_CH; c++) if (cw[c]) begin
      hwm_m[c] = int'(wd[7:0]); sof[c] = 0; suf[c] = 0; pse[c] = 0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (exp_of[c]) sof[c] = 1;
      if (exp_uf[c]) suf[c] = 1;
    end
    @(posedge clk);
    #1;
    if (inj) release dut.g_ch[1].u_ch.par_rd;
    chk("cfg_ack", 64'(cfg_ack), 64'(|strobes));
    chk("cfg_err", 64'(cfg_err), 64'(multi));
    chk("cfg_rdata", 64'(cfg_rdata), 64'(exp_rd));
    chk("error_of", 64'(error_of), 64'(exp_of));
    chk("error_uf", 64'(error_uf), 64'(exp_uf));
    chk("error_par", 64'(error_par), 64'(inj));
    chk("pop_data_v", 64'(pop_data_v), 64'(pop_acc));
    if (pop_acc) chk("pop_data", 64'(pop_data), 64'(exp_pd));
    check_flags("step");
  endtask

  task automatic do_push(input int c);
    step(1, c, 16'($urandom), 0, 0, 4'b0, 4'b0, 32'b0, 0);
  endtask
  task automatic do_pop(input int c);
    step(0, 0, 16'b0, 1, c, 4'b0, 4'b0, 32'b0, 0);
  endtask
  task automatic do_cfg(input logic [3:0] cw, input logic [3:0] cr, input logic [31:0] wd);
    step(0, 0, 16'b0, 0, 0, cw, cr, wd, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    rst_n = 1'b0;
    push = 0; pop = 0; push_ch = 0; pop_ch = 0; push_data = 0;
    cfg_write = 0; cfg_read = 0; cfg_req = '0; bad_par = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.empty", 64'(fifo_empty), 64'hF);
    chk("rst.full", 64'(fifo_full), 64'h0);
    chk("rst.afull", 64'(fifo_afull), 64'h0);
    chk("rst.cfg_ack", 64'(cfg_ack), 64'h0);
    chk("rst.cfg_rdata", 64'(cfg_rdata), 64'h0);
    chk("rst.pop_data_v", 64'(pop_data_v), 64'h0);
    chk("rst.mem_we", 64'(mem_we), 64'h0);
    chk("rst.mem_re", 64'(mem_re), 64'h0);
    chk("rst.errors", 64'({error_of, error_uf, error_par}), 64'h0);
    rst_n = 1'b1;

    // Fill channel 2 to full, then overflow it
    for (int i = 0; i < 9; i++) do_push(2);

    // Underflow channel 1, observe and clear its sticky flag
    do_pop(1);
    do_cfg(4'b0000, 4'b0010, 32'h0);
    do_cfg(4'b0010, 4'b0000, 32'h0000_0001);
    do_cfg(4'b0000, 4'b0010, 32'h0);

    // Channel 0 watermark of 3
    do_cfg(4'b0001, 4'b0000, 32'hABCD_0003);
    for (int i = 0; i < 3; i++) do_push(0);
    do_pop(0);
    do_cfg(4'b0000, 4'b0001, 32'h0);

    // Channel 3 simultaneous push/pop at size 4, wrapping the pointers
    for (int i = 0; i < 4; i++) do_push(3);
    for (int i = 0; i < 20; i++) step(1, 3, 16'($urandom), 1, 3, 4'b0, 4'b0, 32'b0, 0);
    do_cfg(4'b0000, 4'b1000, 32'h0);

    // Parity upset on channel 1, then an upset coinciding with a write
    do_cfg(4'b0010, 4'b0000, 32'h0000_0006);
    step(0, 0, 16'b0, 0, 0, 4'b0, 4'b0, 32'b0, 1);
    do_cfg(4'b0000, 4'b0010, 32'h0);
    step(0, 0, 16'b0, 0, 0, 4'b0010, 4'b0, 32'h0000_0005, 1);
    do_cfg(4'b0000, 4'b0010, 32'h0);

    // Multiple strobes are rejected without side effects
    do_cfg(4'b0011, 4'b0000, 32'h0000_0007);
    do_cfg(4'b0000, 4'b0001, 32'h0);
    do_cfg(4'b0000, 4'b0010, 32'h0);
    do_cfg(4'b0100, 4'b0100, 32'h0000_0002);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] cw, cr;
      cw = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      cr = ($urandom_range(0, 5) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
      r = $urandom;
      r[7:0] = 8'($urandom_range(0, 10));
      step($urandom_range(0, 1), $urandom_range(0, 3), 16'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 3), cw, cr, r, 0);
    end

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) do_push(0);
    rst_n = 1'b0;
    push = 0; pop = 0; cfg_write = 0; cfg_read = 0;
    #2;
    chk("midrst.empty", 64'(fifo_empty), 64'hF);
    chk("midrst.full", 64'(fifo_full), 64'h0);
    chk("midrst.pop_data_v", 64'(pop_data_v), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst.pop_data_v2", 64'(pop_data_v), 64'h0);
    rst_n = 1'b1;
    do_pop(0);
    do_cfg(4'b0000, 4'b0001, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
